router_pkt_src: RTL and testbench
=================================

// Module: router_pkt_src
// PURPOSE
//  Packet source for the router input port: the transmit end of the router's
//  packet protocol (header, payload, parity, with busy backpressure).
//  Takes a per-packet request plus a payload byte stream from the host and
//  buffers the whole payload internally, so pkt_valid never gaps mid-packet.
//  Then emits the packet on data_out/pkt_valid, honouring router busy.
//  Sits between the host/traffic logic and the router top's data_in/pkt_valid/busy.
// PARAMETERS
//  MAX_LEN     63  largest legal payload length in bytes (6-bit length field)
//  GAP_CYCLES  2   minimum idle cycles after a parity byte before the next header
// PORTS
//  clock      in   1  single clock, all logic on its rising edge
//  resetn     in   1  asynchronous active-low reset
//  req_valid  in   1  host request: new packet
//  req_addr   in   2  destination port 0..2 (3 is illegal)
//  req_len    in   6  payload length 1..MAX_LEN (0 is illegal)
//  req_ready  out  1  request accepted on an edge where req_valid&req_ready
//  req_err    out  1  1-cycle pulse: illegal request rejected
//  pl_valid   in   1  payload byte valid
//  pl_data    in   8  payload byte
//  pl_ready   out  1  payload byte accepted on an edge where pl_valid&pl_ready
//  busy       in   1  router busy; 1 = hold current byte
//  data_out   out  8  byte to router data_in
//  pkt_valid  out  1  1 during header and payload, 0 during parity and idle
//  pkt_done   out  1  1-cycle pulse: parity byte taken by router
// BEHAVIOUR
//  Reset (async, resetn=0):
//   - state=IDLE; data_out=0, pkt_valid=0, pkt_done=0, req_err=0, pl_ready=0.
//   - Byte counters and parity are cleared; any partial packet is discarded.
//  Outputs: data_out, pkt_valid, pkt_done and req_err are registered;
//   req_ready and pl_ready are decoded from state.
//  Header byte: {len[5:0], addr[1:0]}.
//  Parity byte: XOR of the header and all payload bytes, accumulated during LOAD.
//  "Taken": a byte is taken on a rising edge where busy==0.
//   While busy==1, data_out and pkt_valid hold unchanged.
//  FSM states:
//   IDLE: req_ready=1, data_out=0, pkt_valid=0.
//    - Accept with addr==3 or len==0: req_err pulses the next cycle; stay IDLE.
//    - Accept otherwise: latch addr/len, parity<=header, cnt<=0 -> LOAD.
//   LOAD: pl_ready=1.
//    - Each accepted byte: mem[cnt]<=pl_data, parity^=pl_data, cnt++.
//    - On the byte with cnt==len-1 -> HDR; no stall bubble is required.
//   HDR: data_out=header, pkt_valid=1.
//    - When taken -> PLD with idx=0.
//   PLD: data_out=mem[idx], pkt_valid=1.
//    - When taken, idx++.
//    - When idx==len-1 is taken -> PAR.
//   PAR: data_out=parity, pkt_valid=0.
//    - When taken: pkt_done pulses the next cycle -> GAP.
//   GAP: data_out=0, pkt_valid=0 for GAP_CYCLES cycles -> IDLE.
//  Latency:
//   - The header appears the cycle after the last payload byte is accepted.
//   - With busy=0 throughout, a packet occupies len+2 consecutive cycles on data_out.
//  Boundaries:
//   - len==1: HDR, one PLD cycle, PAR.
//   - len==MAX_LEN: 63 buffer entries are used with no wrap; idx/cnt are 6-bit.
//   - busy asserting in any HDR/PLD/PAR cycle holds that byte; none is skipped or duplicated.
//   - busy is ignored in IDLE/LOAD/GAP.
//   - req_valid outside IDLE and pl_valid outside LOAD are ignored (ready=0).
//   - resetn low mid-packet: pkt_valid drops immediately (async); the packet is lost.
// TESTING
//  1. Reset: resetn=0 -> data_out=0, pkt_valid=0, req_ready=1, pl_ready=0.
//  2. addr=1, len=3, payload 11,22,33, busy=0 -> data_out 0D,11,22,33 with pkt_valid=1.
//     Then 0D (parity) with pkt_valid=0, then pkt_done pulses once.
//  3. As test 2, but busy=1 for the 2 cycles after the header appears -> 0D held 3 cycles.
//     The byte sequence is unchanged and parity is still 0D.
//  4. req addr=3, len=5 -> req_err pulses 1 cycle, state stays IDLE, pkt_valid never 1.
//     Repeat with addr=0, len=0: same response.
//  5. addr=2, len=63, payload 00..3E -> header FE, then 63 bytes in order.
//     pkt_valid stays 1 for 64 cycles, parity = FE ^ XOR(00..3E).
//  6. Back-to-back requests: next header no earlier than GAP_CYCLES+1 cycles after parity taken.
//     Separately, resetn pulsed low mid-PLD -> pkt_valid=0 at once; a following clean packet is correct.

Source files
------------

// File: rtl/router_pkt_src.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkt_src
//  Description : Router input-port packet source. Buffers a whole payload,
//                then emits header / payload / parity under busy backpressure.
//  Revision    : 1.0  initial release
// ============================================================================
module router_pkt_src #(
  parameter int MAX_LEN    = 63,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       req_valid,
  input  logic [1:0] req_addr,
  input  logic [5:0] req_len,
  output logic       req_ready,
  output logic       req_err,
  input  logic       pl_valid,
  input  logic [7:0] pl_data,
  output logic       pl_ready,
  input  logic       busy,
  output logic [7:0] data_out,
  output logic       pkt_valid,
  output logic       pkt_done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_HDR  = 3'd2,
    S_PLD  = 3'd3,
    S_PAR  = 3'd4,
    S_GAP  = 3'd5
  } state_t;

  localparam logic [7:0] c_gap_last = 8'(GAP_CYCLES - 1);

  state_t     r_state;
  logic [1:0] r_addr;
  logic [5:0] r_len;
  logic [5:0] r_cnt;
  logic [5:0] r_idx;
  logic [7:0] r_parity;
  logic [7:0] r_gap_cnt;
  logic [7:0] r_mem [0:MAX_LEN-1];

  logic       w_req_acc;
  logic       w_req_legal;
  logic       w_pl_acc;
  logic [5:0] w_last;

  assign req_ready   = (r_state == S_IDLE);
  assign pl_ready    = (r_state == S_LOAD);
  assign w_req_acc   = req_valid & req_ready;
  assign w_pl_acc    = pl_valid & pl_ready;
  assign w_req_legal = (req_addr != 2'd3) && (req_len != 6'd0) && (int'(req_len) <= MAX_LEN);
  assign w_last      = r_len - 6'd1;

  // Payload buffer carries no reset: contents are only read after being written.
  always_ff @(posedge clock) begin
    if (w_pl_acc) begin
      r_mem[r_cnt] <= pl_data;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_addr    <= 2'd0;
      r_len     <= 6'd0;
      r_cnt     <= 6'd0;
      r_idx     <= 6'd0;
      r_parity  <= 8'd0;
      r_gap_cnt <= 8'd0;
      data_out  <= 8'd0;
      pkt_valid <= 1'b0;
      pkt_done  <= 1'b0;
      req_err   <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      req_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req_acc) begin
            if (w_req_legal) begin
              r_addr   <= req_addr;
              r_len    <= req_len;
              r_parity <= {req_len, req_addr};
              r_cnt    <= 6'd0;
              r_state  <= S_LOAD;
            end else begin
              req_err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (w_pl_acc) begin
            r_parity <= r_parity ^ pl_data;
            r_cnt    <= r_cnt + 6'd1;
            if (r_cnt == w_last) begin
              data_out  <= {r_len, r_addr};
              pkt_valid <= 1'b1;
              r_state   <= S_HDR;
            end
          end
        end
        S_HDR: begin
          if (!busy) begin
            r_idx    <= 6'd0;
            data_out <= r_mem[0];
            r_state  <= S_PLD;
          end
        end
        S_PLD: begin
          if (!busy) begin
            if (r_idx == w_last) begin
              data_out  <= r_parity;
              pkt_valid <= 1'b0;
              r_state   <= S_PAR;
            end else begin
              r_idx    <= r_idx + 6'd1;
              data_out <= r_mem[r_idx + 6'd1];
            end
          end
        end
        S_PAR: begin
          if (!busy) begin
            data_out  <= 8'd0;
            pkt_done  <= 1'b1;
            r_gap_cnt <= 8'd0;
            r_state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == c_gap_last) begin
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 8'd1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          data_out  <= 8'd0;
          pkt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_src.sv
`default_nettype none
// ============================================================================
//  Module      : tb_router_pkt_src
//  Description : Directed self-checking bench for router_pkt_src.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_router_pkt_src;

  logic       clock;
  logic       resetn;
  logic       req_valid;
  logic [1:0] req_addr;
  logic [5:0] req_len;
  logic       req_ready;
  logic       req_err;
  logic       pl_valid;
  logic [7:0] pl_data;
  logic       pl_ready;
  logic       busy;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       pkt_done;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] pl_buf [0:62];

  router_pkt_src #(.MAX_LEN(63), .GAP_CYCLES(2)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_ready (req_ready),
    .req_err   (req_err),
    .pl_valid  (pl_valid),
    .pl_data   (pl_data),
    .pl_ready  (pl_ready),
    .busy      (busy),
    .data_out  (data_out),
    .pkt_valid (pkt_valid),
    .pkt_done  (pkt_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Request plus payload load; returns at posedge+1 of the expected header cycle.
  task automatic start_packet(input logic [1:0] a, input logic [5:0] l);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < int'(l); i++) begin
      pl_valid = 1'b1;
      pl_data  = pl_buf[i];
      tick();
    end
    pl_valid = 1'b0;
  endtask

  task automatic run_packet(input logic [1:0] a, input logic [5:0] l,
                            input int bs, input int bn);
    logic [7:0] hdr;
    logic [7:0] par;
    logic [7:0] prev_d;
    logic       prev_v;
    logic       prev_b;
    int         cyc;
    int         nbytes;
    bit         done;
    hdr = {l, a};
    par = hdr;
    for (int i = 0; i < int'(l); i++) par = par ^ pl_buf[i];
    start_packet(a, l);
    cyc = 0; nbytes = 0; done = 0; prev_b = 1'b0; prev_d = 8'd0; prev_v = 1'b0;
    while (!done && cyc < 200) begin
      busy = (cyc >= bs) && (cyc < bs + bn);
      @(negedge clock);
      if (prev_b) chk("hold", {23'd0, pkt_valid, data_out}, {23'd0, prev_v, prev_d});
      if (!busy) begin
        if (nbytes == 0) begin
          chk("hdr", {23'd0, pkt_valid, data_out}, {23'd0, 1'b1, hdr});
        end else if (nbytes <= int'(l)) begin
          chk("pld", {23'd0, pkt_valid, data_out}, {23'd0, 1'b1, pl_buf[nbytes-1]});
        end else begin
          chk("par", {23'd0, pkt_valid, data_out}, {23'd0, 1'b0, par});
          done = 1;
        end
        nbytes++;
      end
      prev_b = busy; prev_d = data_out; prev_v = pkt_valid;
      @(posedge clock);
      #1;
      cyc++;
    end
    busy = 1'b0;
    chk("no_timeout", 32'(done), 32'd1);
    chk("pkt_cycles", 32'(cyc), 32'(int'(l) + 2 + bn));
    chk("pkt_done", {30'd0, pkt_done, pkt_valid}, {30'd0, 1'b1, 1'b0});
    chk("gap_data", 32'(data_out), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_addr = 2'd0; req_len = 6'd0;
    pl_valid = 1'b0; pl_data = 8'd0; busy = 1'b0;

    // 1. reset state
    #2;
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_flags", {28'd0, pkt_valid, pkt_done, req_err, pl_ready}, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    tick();
    resetn = 1'b1;
    tick();

    // 2. basic packet
    pl_buf[0] = 8'h11; pl_buf[1] = 8'h22; pl_buf[2] = 8'h33;
    run_packet(2'd1, 6'd3, 0, 0);
    tick(); tick();

    // 3. busy on header, then busy in payload, then busy on parity with len 1
    run_packet(2'd1, 6'd3, 0, 2);
    tick(); tick();
    run_packet(2'd1, 6'd3, 3, 2);
    tick(); tick();
    pl_buf[0] = 8'hA5;
    run_packet(2'd0, 6'd1, 2, 1);
    tick(); tick();

    // 4. illegal requests
    req_valid = 1'b1; req_addr = 2'd3; req_len = 6'd5;
    tick();
    req_valid = 1'b0;
    chk("err_addr", {29'd0, req_err, req_ready, pkt_valid}, {29'd0, 1'b1, 1'b1, 1'b0});
    tick();
    chk("err_addr_pulse", {30'd0, req_err, pl_ready}, 32'd0);
    req_valid = 1'b1; req_addr = 2'd0; req_len = 6'd0;
    tick();
    req_valid = 1'b0;
    chk("err_len", {29'd0, req_err, req_ready, pkt_valid}, {29'd0, 1'b1, 1'b1, 1'b0});
    tick();
    chk("err_len_pulse", {30'd0, req_err, pl_ready}, 32'd0);

    // 5. maximum length
    for (int i = 0; i < 63; i++) pl_buf[i] = 8'(i);
    run_packet(2'd2, 6'd63, 0, 0);

    // 6a. gap: requests ignored while GAP, accepted once IDLE
    chk("gap0_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b1; req_addr = 2'd3; req_len = 6'd1;
    tick();
    req_valid = 1'b0;
    chk("gap1", {28'd0, req_ready, req_err, pl_ready, pkt_valid}, 32'd0);
    tick();
    chk("gap_end", {30'd0, req_ready, req_err}, {30'd0, 1'b1, 1'b0});
    pl_buf[0] = 8'h5A; pl_buf[1] = 8'hC3;
    run_packet(2'd2, 6'd2, 1, 1);
    tick(); tick();

    // 6b. async reset mid-payload
    for (int i = 0; i < 4; i++) pl_buf[i] = 8'hF0 + 8'(i);
    start_packet(2'd0, 6'd4);
    tick(); tick();
    chk("pre_rst_valid", 32'(pkt_valid), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst", {22'd0, pkt_valid, req_ready, data_out}, {22'd0, 1'b0, 1'b1, 8'd0});
    @(negedge clock);
    resetn = 1'b1;
    tick();
    pl_buf[0] = 8'h01; pl_buf[1] = 8'h80;
    run_packet(2'd1, 6'd2, 0, 0);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
